// File: rtl/logic_gate_pkg.sv
// Shared encodings for the logic gate accumulator: op codes, FSM states,
// and helpers mapping an op code to its per-beat base operation.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Inverting ops fold with their base op; the inversion happens once at the output.
  // Reserved codes fall back to OR.
  function automatic op_e base_op(input logic [2:0] op);
    case (op)
      3'd0, 3'd3: base_op = OP_AND;
      3'd2, 3'd5: base_op = OP_XOR;
      default:    base_op = OP_OR;
    endcase
  endfunction

  function automatic logic is_inverting(input logic [2:0] op);
    is_inverting = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
  endfunction

endpackage

// File: rtl/logic_gate_accumulator_if.sv
// Operand/result handshake bundle for the logic gate accumulator.
// master drives operands and out_ready; slave is the accumulator itself.
interface logic_gate_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);

  logic [WIDTH-1:0] a;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic [CNT_W-1:0] beats;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, op, in_valid, in_last, out_ready,
    input  in_ready, y0, beats, overflow, out_valid
  );

  modport slave (
    input  a, op, in_valid, in_last, out_ready,
    output in_ready, y0, beats, overflow, out_valid
  );

endinterface

// File: rtl/logic_gate_op.sv
// Combinational per-beat fold: y = a (base op of op) b.
// Inverting ops reduce to their base op here; inversion is left to the caller.
module logic_gate_op
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a | b;
    case (base_op(op))
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/logic_gate_accumulator.sv
// Folds a frame of operand beats with a bitwise gate op and holds the result
// until the consumer takes it; frames longer than MAX_BEATS are cut off.
module logic_gate_accumulator
  import logic_gate_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  logic_gate_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] acc_next;
  logic [2:0]       op_q;
  logic [2:0]       op_eff;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             deliver;
  logic             cap_hit;
  logic             frame_end;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             overflow_q;
  logic [WIDTH-1:0] y0_q;
  logic [CNT_W-1:0] beats_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.y0        = y0_q;
  assign bus.beats     = beats_q;

  logic_gate_op #(.WIDTH(WIDTH)) u_op (
    .a  (acc),
    .b  (bus.a),
    .op (op_q),
    .y  (fold)
  );

  // The first beat of a frame loads directly and uses the live op; later beats fold with the latched op.
  always_comb begin
    accept     = bus.in_valid && in_ready_q;
    deliver    = out_valid_q && bus.out_ready;
    op_eff     = (state == ST_IDLE) ? bus.op : op_q;
    acc_next   = (state == ST_IDLE) ? bus.a : fold;
    count_next = (state == ST_IDLE) ? CNT_W'(1) : count + CNT_W'(1);
    cap_hit    = (count_next == CNT_W'(MAX_BEATS));
    frame_end  = accept && (bus.in_last || cap_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      count       <= '0;
      op_q        <= 3'd0;
      y0_q        <= '0;
      beats_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc   <= acc_next;
            count <= count_next;
            if (state == ST_IDLE) op_q <= bus.op;
            if (frame_end) begin
              state       <= ST_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              y0_q        <= is_inverting(op_eff) ? ~acc_next : acc_next;
              beats_q     <= count_next;
              // Reaching frame_end without in_last can only mean the beat cap cut the frame.
              overflow_q  <= !bus.in_last;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (deliver) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
